// File: rtl/sudoku_ctrl.sv
// Host-side sequencer: streams a puzzle into the solver wrapper RAM, starts the solver, streams the result back.
// Optional solve-phase watchdog enabled by defining SUDOKU_CTRL_TIMEOUT_EN.
module sudoku_ctrl #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_digit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_digit,
    output logic       out_last,
    output logic       busy,
    output logic       solved,
    output logic       failed,
    output logic       bad_input,
    output logic       timed_out,
    output logic [6:0] ram_addr,
    output logic       ram_wr,
    output logic [8:0] ram_din,
    input  logic [8:0] ram_dout,
    output logic       slv_start,
    input  logic       slv_done,
    input  logic       slv_error,
    output logic       slv_rst
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_SOLVE,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t     state;
    state_t     next;
    logic [6:0] cnt;
    logic       last_cell;
    logic       illegal;
    logic       expire;
    logic [8:0] enc;
    logic [3:0] dec;

    assign last_cell = (cnt == 7'd80);
    assign illegal   = (in_digit >= 4'd10);

    always_comb begin
        if (in_digit == 4'd0 || illegal) begin
            enc = '1;
        end else begin
            enc = 9'b1 << (in_digit - 4'd1);
        end
    end

    // Anything other than exactly one candidate bit decodes to 0.
    always_comb begin
        dec = '0;
        for (int unsigned k = 0; k < 9; k++) begin
            if (ram_dout == (9'b1 << k)) begin
                dec = 4'(k + 1);
            end
        end
    end

`ifdef SUDOKU_CTRL_TIMEOUT_EN
    logic [31:0] tcnt;

    // A solver finish on the expiry cycle takes priority over the timeout.
    assign expire = (state == S_SOLVE) && !slv_done && !slv_error &&
                    (tcnt == TIMEOUT_CYCLES - 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt      <= '0;
            timed_out <= 1'b0;
        end else begin
            if (state == S_START) begin
                tcnt <= '0;
            end else if (state == S_SOLVE) begin
                tcnt <= tcnt + 32'd1;
            end
            if (state == S_IDLE && in_valid) begin
                timed_out <= 1'b0;
            end else if (expire) begin
                timed_out <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign expire         = 1'b0;
    assign timed_out      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            S_IDLE:  if (in_valid) next = S_LOAD;
            S_LOAD:  if (in_valid && last_cell) next = S_START;
            S_START: next = S_SOLVE;
            S_SOLVE: if (slv_done || slv_error || expire) next = S_DRAIN;
            S_DRAIN: next = S_OUT;
            S_OUT:   if (out_ready && last_cell) next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            solved    <= 1'b0;
            failed    <= 1'b0;
            bad_input <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        cnt       <= '0;
                        solved    <= 1'b0;
                        failed    <= 1'b0;
                        bad_input <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (illegal) begin
                            bad_input <= 1'b1;
                        end
                        cnt <= last_cell ? 7'd0 : cnt + 7'd1;
                    end
                end
                S_SOLVE: begin
                    if (slv_done) begin
                        solved <= 1'b1;
                    end else if (slv_error || expire) begin
                        failed <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    cnt <= '0;
                end
                S_OUT: begin
                    if (out_ready) begin
                        cnt <= last_cell ? 7'd0 : cnt + 7'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == S_LOAD);
        ram_wr    = (state == S_LOAD) && in_valid;
        ram_addr  = cnt;
        ram_din   = (state == S_LOAD) ? enc : '0;
        slv_start = (state == S_START);
        out_valid = (state == S_OUT);
        out_digit = (state == S_OUT) ? dec : '0;
        out_last  = (state == S_OUT) && last_cell;
        busy      = (state != S_IDLE);
        slv_rst   = rst || expire;
    end

endmodule

// File: tb/tb_sudoku_ctrl.sv
// Self-checking bench for sudoku_ctrl: RAM and solver models, golden grid built from a Latin pattern.
// Define SUDOKU_CTRL_TIMEOUT_EN for both RTL and bench to exercise the watchdog.
module tb_sudoku_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_digit = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_digit;
    logic       out_last;
    logic       busy, solved, failed, bad_input, timed_out;
    logic [6:0] ram_addr;
    logic       ram_wr;
    logic [8:0] ram_din;
    logic [8:0] ram_dout;
    logic       slv_start;
    logic       slv_done = 1'b0;
    logic       slv_error = 1'b0;
    logic       slv_rst;

    sudoku_ctrl #(.TIMEOUT_CYCLES(32'd64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_digit(in_digit),
        .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit), .out_last(out_last),
        .busy(busy), .solved(solved), .failed(failed), .bad_input(bad_input), .timed_out(timed_out),
        .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_din(ram_din), .ram_dout(ram_dout),
        .slv_start(slv_start), .slv_done(slv_done), .slv_error(slv_error), .slv_rst(slv_rst)
    );

    always #5 clk = ~clk;

    // Wrapper grid RAM; sol_load models the wrapper copying the solver grid in.
    logic [8:0] mem [0:127];
    logic       sol_load = 1'b0;
    logic [8:0] sol [0:80];
    int         nstart = 0;

    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_din;
        if (sol_load) for (int i = 0; i < 81; i++) mem[i] <= sol[i];
        if (slv_start) nstart <= nstart + 1;
    end
    assign ram_dout = mem[ram_addr];

    int total = 0;
    int bad = 0;
    int puz [0:80];
    int gold [0:80];
    int expd [0:80];
    int perm [0:8] = '{5, 3, 4, 6, 7, 8, 9, 1, 2};
    int n0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] enc_m(input int d);
        if (d >= 1 && d <= 9) return 9'(1 << (d - 1));
        return 9'h1FF;
    endfunction

    function automatic int dec_m(input logic [8:0] v);
        if ($countones(v) == 1) return $clog2(v) + 1;
        return 0;
    endfunction

    task automatic make_puzzle();
        int n;
        for (int i = 0; i < 81; i++) puz[i] = 0;
        puz[0] = gold[0];
        puz[1] = gold[1];
        n = 2;
        while (n < 30) begin
            int j;
            j = $urandom_range(2, 80);
            if (puz[j] == 0) begin
                puz[j] = gold[j];
                n++;
            end
        end
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            bit hs;
            hs = 1'b0;
            if (i % 3 == 2) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_digit = 4'(puz[i]);
            for (int w = 0; w < 10 && !hs; w++) begin
                @(negedge clk);
                if (in_ready) begin
                    chk("load_wr", ram_wr, 1);
                    chk("load_addr", ram_addr, i);
                    chk("load_din", ram_din, enc_m(puz[i]));
                    hs = 1'b1;
                end
                @(posedge clk); #1;
            end
            if (!hs) chk("load_budget", 0, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic start_chk();
        @(negedge clk);
        chk("start_pulse", slv_start, 1);
        chk("start_busy", busy, 1);
        @(posedge clk);
        @(negedge clk);
        chk("start_single", slv_start, 0);
        chk("solve_slv_rst", slv_rst, 0);
    endtask

    task automatic run_solve(input int w, input bit err);
        repeat (w) @(posedge clk);
        @(posedge clk); #1;
        if (err) slv_error = 1'b1; else slv_done = 1'b1;
        sol_load = 1'b1;
        @(posedge clk); #1;
        slv_done = 1'b0;
        slv_error = 1'b0;
        sol_load = 1'b0;
        @(negedge clk);
        chk("drain_no_valid", out_valid, 0);
        chk("solved_flag", solved, !err);
        chk("failed_flag", failed, err);
    endtask

    task automatic readout(input int n);
        int beat;
        beat = 0;
        for (int c = 0; c < 4000 && beat < n; c++) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("out_valid", out_valid, 1);
            chk("out_digit", out_digit, expd[beat]);
            chk("out_last", out_last, beat == 80);
            if (out_ready) beat++;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (beat < n) chk("readout_budget", beat, n);
        if (n == 81) begin
            @(negedge clk);
            chk("end_idle", busy, 0);
            chk("end_no_valid", out_valid, 0);
        end
    endtask

    task automatic reset_chk(input string tag);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_flags"}, {solved, failed, bad_input, timed_out}, 0);
        chk({tag, "_slv_rst"}, slv_rst, 1);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                gold[r * 9 + c] = perm[(r * 3 + r / 3 + c) % 9];

        // reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_start", slv_start, 0);
        chk("rst_wr", ram_wr, 0);
        chk("rst_flags", {solved, failed, bad_input, timed_out}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // solvable puzzle, done after ~100 cycles
        make_puzzle();
        chk("cell0_enc", enc_m(puz[0]), 9'h010);
        n0 = nstart;
        load(81);
        start_chk();
        for (int i = 0; i < 81; i++) begin
            sol[i] = enc_m(gold[i]);
            expd[i] = gold[i];
        end
        run_solve(98, 1'b0);
        readout(81);
        chk("start_once", nstart - n0, 1);

        // illegal digit and contradictory givens, solver errors out
        for (int i = 0; i < 81; i++) puz[i] = 0;
        puz[0] = 5; puz[1] = 5; puz[9] = 5; puz[5] = 12;
        load(81);
        start_chk();
        chk("bad_input_set", bad_input, 1);
        chk("solved_cleared", solved, 0);
        for (int i = 0; i < 81; i++) begin
            case ($urandom_range(0, 2))
                0: sol[i] = 9'(1 << $urandom_range(0, 8));
                1: sol[i] = 9'($urandom);
                default: sol[i] = '0;
            endcase
        end
        sol[3] = 9'h003;
        for (int i = 0; i < 81; i++) expd[i] = dec_m(sol[i]);
        run_solve(50, 1'b1);
        chk("bad_input_held", bad_input, 1);
        readout(81);

        // solver outputs outside SOLVE are ignored
        slv_done = 1'b1;
        @(posedge clk); #1;
        slv_done = 1'b0;
        @(negedge clk);
        chk("idle_done_ignored", {busy, solved, failed}, 3'b001);

        // reset in OUT at beat 20
        make_puzzle();
        load(81);
        start_chk();
        for (int i = 0; i < 81; i++) begin
            sol[i] = enc_m(gold[i]);
            expd[i] = gold[i];
        end
        run_solve(10, 1'b0);
        readout(20);
        reset_chk("rst_out");

        // reset in LOAD at cell 40
        puz[3] = 14;
        load(40);
        reset_chk("rst_load");

        // fresh run must load from cell 0
        make_puzzle();
        load(81);
        start_chk();
        run_solve(20, 1'b0);
        readout(81);

`ifdef SUDOKU_CTRL_TIMEOUT_EN
        // solver never finishes: watchdog expires on SOLVE cycle 64
        make_puzzle();
        load(81);
        start_chk();
        for (int i = 2; i <= 64; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("to_slv_rst", slv_rst, i == 64);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("to_timed_out", timed_out, 1);
        chk("to_failed", failed, 1);
        chk("to_solved", solved, 0);
        chk("to_drain", out_valid, 0);
        for (int i = 0; i < 81; i++) expd[i] = dec_m(enc_m(puz[i]));
        readout(81);

        // done on the expiry cycle wins
        make_puzzle();
        load(81);
        start_chk();
        for (int i = 2; i <= 63; i++) @(posedge clk);
        @(posedge clk); #1;
        for (int i = 0; i < 81; i++) begin
            sol[i] = enc_m(gold[i]);
            expd[i] = gold[i];
        end
        slv_done = 1'b1;
        sol_load = 1'b1;
        @(negedge clk);
        chk("race_slv_rst", slv_rst, 0);
        @(posedge clk); #1;
        slv_done = 1'b0;
        sol_load = 1'b0;
        @(negedge clk);
        chk("race_flags", {solved, failed, timed_out}, 3'b100);
        readout(81);
`else
        chk("timed_out_tied", timed_out, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
